fusion_seq_ctrl: RTL and testbench
==================================

// Module: fusion_seq_ctrl
// PURPOSE
//  Temporal sequencer for the BitFusion datapath. Accepts one activation/weight pair
//  with per-operand bitwidth codes and decomposes it into 2-bit x 2-bit bricks.
//  Processes one brick per cycle, shifting each brick product by 2*(row+col) and
//  accumulating it into a 32-bit result. Sits between the operand buffer and the
//  output/accumulation stage, and reuses the 001/010/100 width encoding of shift_add.
// PARAMETERS
//  ACC_W    32  accumulator and result width (wraps two's complement)
//  OP_W     8   maximum operand width (4 bricks of 2 bits)
// PORTS
//  clk              in   1      system clock
//  n_rst            in   1      synchronous active-low reset
//  in_valid         in   1      job request
//  in_ready         out  1      job accepted when in_valid&in_ready at clk edge
//  in_act           in   OP_W   activation; bits above 2*nI ignored
//  in_wgt           in   OP_W   weight; bits above 2*nW ignored
//  input_bitwidth   in   3      001=2b (nI=1), 010=4b (nI=2), 100=8b (nI=4)
//  weight_bitwidth  in   3      same encoding, gives nW
//  acc_en           in   1      1: start from held result; 0: start from 0
//  out_valid        out  1      result available
//  out_ready        in   1      result consumed when out_valid&out_ready at edge
//  out_result       out  ACC_W  signed accumulated result
//  out_err          out  1      job carried an illegal bitwidth code
//  busy             out  1      state != IDLE
// BEHAVIOUR
//  - Reset (n_rst=0 at edge): state=IDLE, accumulator=0, row/col counters=0,
//    out_valid=0, out_err=0, out_result=0, in_ready=1 after reset. Reset mid-job
//    aborts the job; no result is produced.
//  - FSM IDLE->RUN->DONE->IDLE. in_ready=1 only in IDLE, so jobs never overlap.
//  - IDLE: on accept, latch operands, nI, nW and acc_en. Set row=col=0. Set
//    acc to the held result if acc_en=1, else to 0. Go to RUN.
//    An illegal code (any value other than 001/010/100 on either width) goes straight
//    to DONE with out_err=1 and out_result=0; the held accumulator is not modified.
//  - RUN: each cycle computes a_brk=act[2r+1:2r] and w_brk=wgt[2c+1:2c], then
//    acc += (a_brk*w_brk) <<< 2*(r+c), sign-extended to ACC_W.
//    col is the inner loop (0..nW-1) and row the outer loop (0..nI-1).
//    The last brick (r=nI-1, c=nW-1) moves the FSM to DONE.
//  - Latency: for an accepted job at edge E0, out_valid is high after edge E(nI*nW).
//    Cycle counts are 1 (2x2), 4 (4x4) and 16 (8x8).
//  - DONE: out_valid=1. out_result and out_err are held stable until out_ready=1.
//    The handshake edge returns the FSM to IDLE. The result stays in a holding register
//    for the next acc_en job. out_ready is ignored when out_valid=0.
//  - Overflow wraps modulo 2^ACC_W; no saturation and no flag.
//  - Unsigned build: every brick is an unsigned 2-bit value (0..3), and the product
//    is in the range 0..9.
// CONFIGURATION
//  FUSION_SIGNED_EN defined: operands are two's complement at their declared width.
//    The top brick (row nI-1 / col nW-1) is signed (-2..1) and the lower bricks are
//    unsigned. Brick products lie in -6..9 and are signed-extended before the shift.
//  FUSION_SIGNED_EN undefined: all bricks are unsigned and operands are unsigned
//    magnitudes. Ports and timing are identical in both builds.
// TESTING
//  1 act=3,wgt=2,codes 001/001,acc_en=0 -> out_valid 1 cycle after accept,
//    result=6 (unsigned) / 2 (signed: -1*-2).
//  2 act=FF,wgt=FF,codes 100/100 -> 16 RUN cycles, result=65025 (unsigned) / 1 (signed).
//  3 act=A,wgt=03,codes 010/100 -> 8 RUN cycles, result=30 (unsigned) / -18 (signed).
//  4 job 5x5 (010/010,acc_en=0)=25, then 2x3 (010/010,acc_en=1) -> result=31.
//  5 hold out_ready=0 for 3 cycles in DONE -> out_result stable, in_ready=0, busy=1.
//    Then send code 011 -> out_err=1, result=0, and the next acc_en job still adds to 31.
//  6 assert n_rst=0 at RUN cycle 5 of an 8x8 job -> IDLE, out_valid=0,
//    next acc_en=1 job starts from 0.

Source files
------------

// File: rtl/fusion_seq_ctrl.sv
// BitFusion temporal sequencer: splits one act/wgt pair into 2x2-bit bricks and accumulates
// one shifted brick product per cycle. Define FUSION_SIGNED_EN for two's complement operands.
module fusion_seq_ctrl #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OP_W  = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_act,
  input  logic [OP_W-1:0]  in_wgt,
  input  logic [2:0]       input_bitwidth,
  input  logic [2:0]       weight_bitwidth,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned SUM_W  = 3;
  localparam int unsigned SH_W   = 4;
  localparam int unsigned BEXT_W = 3;
  localparam int unsigned PROD_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [OP_W-1:0]           r_act;
  logic [OP_W-1:0]           r_wgt;
  logic [IDX_W-1:0]          r_row;
  logic [IDX_W-1:0]          r_col;
  logic [IDX_W-1:0]          r_row_last;
  logic [IDX_W-1:0]          r_col_last;
  logic [ACC_W-1:0]          r_acc;
  logic [ACC_W-1:0]          r_result;
  logic                      r_err;
  logic                      r_out_valid;
  logic                      r_in_ready;
  logic                      r_busy;

  logic                      w_accept;
  logic                      w_i_ok;
  logic                      w_w_ok;
  logic                      w_codes_ok;
  logic [IDX_W-1:0]          w_i_last;
  logic [IDX_W-1:0]          w_w_last;
  logic                      w_last_brick;
  logic [1:0]                w_a_brk;
  logic [1:0]                w_w_brk;
  logic                      w_a_sgn;
  logic                      w_w_sgn;
  logic signed [BEXT_W-1:0]  w_a_ext;
  logic signed [BEXT_W-1:0]  w_w_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic [SUM_W-1:0]          w_rc_sum;
  logic [SH_W-1:0]           w_shamt;
  logic [ACC_W-1:0]          w_term;
  logic [ACC_W-1:0]          w_acc_sum;

  // One-hot width code to last brick index; anything else is illegal
  always_comb begin
    w_i_ok   = 1'b1;
    w_i_last = '0;
    w_w_ok   = 1'b1;
    w_w_last = '0;
    case (input_bitwidth)
      3'b001:  w_i_last = 2'd0;
      3'b010:  w_i_last = 2'd1;
      3'b100:  w_i_last = 2'd3;
      default: w_i_ok   = 1'b0;
    endcase
    case (weight_bitwidth)
      3'b001:  w_w_last = 2'd0;
      3'b010:  w_w_last = 2'd1;
      3'b100:  w_w_last = 2'd3;
      default: w_w_ok   = 1'b0;
    endcase
  end

  assign w_codes_ok   = w_i_ok & w_w_ok;
  assign w_last_brick = (r_row == r_row_last) && (r_col == r_col_last);

  assign w_a_brk = r_act[{r_row, 1'b0} +: 2];
  assign w_w_brk = r_wgt[{r_col, 1'b0} +: 2];

`ifdef FUSION_SIGNED_EN
  // Only the most significant brick of each operand carries the sign
  assign w_a_sgn = (r_row == r_row_last) & w_a_brk[1];
  assign w_w_sgn = (r_col == r_col_last) & w_w_brk[1];
`else
  assign w_a_sgn = 1'b0;
  assign w_w_sgn = 1'b0;
`endif

  assign w_a_ext   = {w_a_sgn, w_a_brk};
  assign w_w_ext   = {w_w_sgn, w_w_brk};
  assign w_prod    = PROD_W'(w_a_ext) * PROD_W'(w_w_ext);
  assign w_rc_sum  = {1'b0, r_row} + {1'b0, r_col};
  assign w_shamt   = {w_rc_sum, 1'b0};
  assign w_term    = ACC_W'(w_prod) <<< w_shamt;
  assign w_acc_sum = r_acc + w_term;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_codes_ok ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_last_brick) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch, brick counters, accumulator and registered status outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_act       <= '0;
      r_wgt       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_row_last  <= '0;
      r_col_last  <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_act      <= in_act;
        r_wgt      <= in_wgt;
        r_row_last <= w_i_last;
        r_col_last <= w_w_last;
        r_row      <= '0;
        r_col      <= '0;
        r_err      <= ~w_codes_ok;
        if (w_codes_ok) begin
          if (!acc_en) begin
            r_acc <= '0;
          end
        end else begin
          r_result <= '0;
        end
      end else if (r_state == S_RUN) begin
        r_acc <= w_acc_sum;
        if (w_last_brick) begin
          r_result <= w_acc_sum;
          r_row    <= '0;
          r_col    <= '0;
        end else if (r_col == r_col_last) begin
          r_col <= '0;
          r_row <= r_row + 2'd1;
        end else begin
          r_col <= r_col + 2'd1;
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_err    = r_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_fusion_seq_ctrl.sv
// Self-checking bench for fusion_seq_ctrl: directed jobs with literal results plus randomized
// jobs against an arithmetic model (result = base + A*W, latency = nI*nW).
module tb_fusion_seq_ctrl;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned OP_W  = 8;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_act;
  logic [OP_W-1:0]  in_wgt;
  logic [2:0]       input_bitwidth;
  logic [2:0]       weight_bitwidth;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_result;
  logic             out_err;
  logic             busy;

  always #5 clk = ~clk;

  fusion_seq_ctrl #(.ACC_W(ACC_W), .OP_W(OP_W)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_act          (in_act),
    .in_wgt          (in_wgt),
    .input_bitwidth  (input_bitwidth),
    .weight_bitwidth (weight_bitwidth),
    .acc_en          (acc_en),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_err         (out_err),
    .busy            (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic        m_busy = 1'b0;
  logic        m_outv = 1'b0;
  logic        m_err  = 1'b0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_hold = '0;
  int          m_rem  = 0;
  logic        last_acc = 1'b0;

  function automatic int n_bricks(input logic [2:0] code);
    case (code)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 4;
      default: return 0;
    endcase
  endfunction

  // Numeric operand value at its declared width
  function automatic int op_val(input logic [7:0] op, input logic [2:0] code);
    int nb;
    int v;
    nb = 2 * n_bricks(code);
    v  = int'(op) & ((1 << nb) - 1);
`ifdef FUSION_SIGNED_EN
    if (v >= (1 << (nb - 1))) v = v - (1 << nb);
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, update the model for that edge, then compare all outputs
  task automatic tick();
    logic acc;
    logic hs;
    logic rst;
    int   ni;
    int   nw;
    acc = in_valid && !m_busy;
    hs  = m_outv && out_ready;
    rst = !n_rst;
    ni  = n_bricks(input_bitwidth);
    nw  = n_bricks(weight_bitwidth);
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_outv = 1'b0; m_err = 1'b0; m_res = '0; m_hold = '0; m_rem = 0;
    end else if (acc) begin
      m_busy = 1'b1;
      if (ni == 0 || nw == 0) begin
        m_outv = 1'b1; m_err = 1'b1; m_res = '0;
      end else begin
        m_rem = ni * nw;
        m_err = 1'b0;
        m_res = (acc_en ? m_hold : 32'd0) +
                32'(op_val(in_act, input_bitwidth) * op_val(in_wgt, weight_bitwidth));
      end
    end else if (m_busy && !m_outv) begin
      m_rem--;
      if (m_rem == 0) begin
        m_outv = 1'b1;
        m_hold = m_res;
      end
    end else if (hs) begin
      m_busy = 1'b0;
      m_outv = 1'b0;
    end
    last_acc = acc && !rst;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_outv));
    if (m_outv) begin
      chk("out_result", out_result, m_res);
      chk("out_err", 32'(out_err), 32'(m_err));
    end
  endtask

  task automatic job(input logic [7:0] a, input logic [7:0] w, input logic [2:0] ci,
                     input logic [2:0] cw, input logic ae, input int hold, input logic rnd_ready,
                     output logic [31:0] res, output logic err);
    int lat;
    int exp_lat;
    exp_lat = n_bricks(ci) * n_bricks(cw);
    in_act = a; in_wgt = w; input_bitwidth = ci; weight_bitwidth = cw; acc_en = ae;
    in_valid = 1'b1;
    last_acc = 1'b0;
    for (int k = 0; k < 10 && !last_acc; k++) tick();
    in_valid = 1'b0;
    n_checks++;
    if (!last_acc) begin
      n_fail++;
      $display("FAIL accept: job not accepted within 10 cycles");
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    res = out_result;
    err = out_err;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_result", out_result, res);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic        err;
    logic [2:0]  codes [13];
    codes = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
              3'b000, 3'b011, 3'b101, 3'b111};
    n_rst = 1'b0; in_valid = 1'b0; in_act = '0; in_wgt = '0;
    input_bitwidth = 3'b001; weight_bitwidth = 3'b001; acc_en = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    chk("rst_result", out_result, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

`ifdef FUSION_SIGNED_EN
    job(8'h03, 8'h02, 3'b001, 3'b001, 1'b0, 0, 1'b0, res, err);
    chk("t1_result", res, 32'd2);
    job(8'hFF, 8'hFF, 3'b100, 3'b100, 1'b0, 0, 1'b0, res, err);
    chk("t2_result", res, 32'd1);
    job(8'h0A, 8'h03, 3'b010, 3'b100, 1'b0, 0, 1'b0, res, err);
    chk("t3_result", res, 32'hFFFF_FFEE);
`else
    job(8'h03, 8'h02, 3'b001, 3'b001, 1'b0, 0, 1'b0, res, err);
    chk("t1_result", res, 32'd6);
    job(8'hFF, 8'hFF, 3'b100, 3'b100, 1'b0, 0, 1'b0, res, err);
    chk("t2_result", res, 32'd65025);
    job(8'h0A, 8'h03, 3'b010, 3'b100, 1'b0, 0, 1'b0, res, err);
    chk("t3_result", res, 32'd30);
`endif
    job(8'h05, 8'h05, 3'b010, 3'b010, 1'b0, 0, 1'b0, res, err);
    chk("t4a_result", res, 32'd25);
    job(8'h02, 8'h03, 3'b010, 3'b010, 1'b1, 3, 1'b0, res, err);
    chk("t4b_result", res, 32'd31);
    job(8'h01, 8'h01, 3'b011, 3'b010, 1'b1, 0, 1'b0, res, err);
    chk("t5_err_result", res, 32'd0);
    chk("t5_err_flag", 32'(err), 32'd1);
    job(8'h01, 8'h01, 3'b010, 3'b010, 1'b1, 0, 1'b0, res, err);
    chk("t5_after_err", res, 32'd32);
    chk("t5_after_err_flag", 32'(err), 32'd0);

    // Abort an 8x8 job part-way through RUN
    in_act = 8'hFF; in_wgt = 8'hFF; input_bitwidth = 3'b100; weight_bitwidth = 3'b100;
    acc_en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_result", out_result, 32'd0);
    job(8'h03, 8'h02, 3'b010, 3'b010, 1'b1, 0, 1'b0, res, err);
    chk("t6_restart", res, 32'd6);

    for (int j = 0; j < 80; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        out_ready = 1'b0;
      end
      job(8'($urandom), 8'($urandom), codes[$urandom_range(0, 12)], codes[$urandom_range(0, 12)],
          1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b1, res, err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
